// File: rtl/wb_commit.sv
// wb_commit: dual-lane writeback stage that holds a MEM bundle until load data returns, then drives both regfile write ports.
// Optional trace PCs (m_pc/s_pc in, dbg_pc1/dbg_pc2 out) are enabled by defining WB_DEBUG_EN.
module wb_commit (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        m_wen,
    input  logic [4:0]  m_waddr,
    input  logic [31:0] m_wdata,
    input  logic        m_is_load,
    input  logic [1:0]  m_load_size,
    input  logic        m_load_sign,
    input  logic [1:0]  m_addr_lo,
    input  logic        s_wen,
    input  logic [4:0]  s_waddr,
    input  logic [31:0] s_wdata,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
`ifdef WB_DEBUG_EN
    input  logic [31:0] m_pc,
    input  logic [31:0] s_pc,
    output logic [31:0] dbg_pc1,
    output logic [31:0] dbg_pc2,
`endif
    output logic        wen1_a,
    output logic [4:0]  waddr1_a,
    output logic [31:0] wdata1_a,
    output logic        wen2_a,
    output logic [4:0]  waddr2_a,
    output logic [31:0] wdata2_a
);
    typedef enum logic [1:0] {IDLE, WAIT, COMMIT} state_t;
    state_t      r_state, w_next;
    logic        r_drop, w_drop_next, w_load_done, w_accept, w_commit;
    logic        r_h_m_wen, r_h_sign, r_h_s_wen;
    logic [4:0]  r_h_m_waddr, r_h_s_waddr;
    logic [1:0]  r_h_size, r_h_lo;
    logic [31:0] r_h_s_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_aligned;
    logic        w_m_wen, w_s_wen, w_wen1, w_wen2;
    logic [4:0]  w_m_waddr, w_s_waddr;
    logic [31:0] w_m_wdata, w_s_wdata;
`ifdef WB_DEBUG_EN
    logic [31:0] r_h_m_pc, r_h_s_pc;
`endif

    assign mem_ready = (r_state != WAIT) && !flush;
    assign w_accept  = mem_valid && mem_ready;

    // flush beats a same-cycle rvalid: that response belongs to the killed load and is simply dropped
    always_comb begin
        w_next      = IDLE;
        w_drop_next = r_drop;
        w_load_done = 1'b0;
        if (r_state == WAIT) begin
            if (flush) begin
                w_drop_next = r_drop | ~dmem_rvalid;
            end else if (dmem_rvalid && r_drop) begin
                w_next      = WAIT;
                w_drop_next = 1'b0;
            end else if (dmem_rvalid) begin
                w_next      = COMMIT;
                w_load_done = 1'b1;
            end else begin
                w_next = WAIT;
            end
        end else begin
            w_drop_next = dmem_rvalid ? 1'b0 : r_drop;
            w_next      = w_accept ? (m_is_load ? WAIT : COMMIT) : IDLE;
        end
    end

    assign w_byte    = dmem_rdata[{r_h_lo, 3'b000} +: 8];
    assign w_half    = dmem_rdata[{r_h_lo[1], 4'b0000} +: 16];
    assign w_aligned = (r_h_size == 2'b00) ? {{24{r_h_sign & w_byte[7]}}, w_byte} :
                       (r_h_size == 2'b01) ? {{16{r_h_sign & w_half[15]}}, w_half} : dmem_rdata;

    assign w_m_wen   = w_load_done ? r_h_m_wen   : m_wen;
    assign w_m_waddr = w_load_done ? r_h_m_waddr : m_waddr;
    assign w_m_wdata = w_load_done ? w_aligned   : m_wdata;
    assign w_s_wen   = w_load_done ? r_h_s_wen   : s_wen;
    assign w_s_waddr = w_load_done ? r_h_s_waddr : s_waddr;
    assign w_s_wdata = w_load_done ? r_h_s_wdata : s_wdata;
    assign w_wen2    = w_s_wen && (w_s_waddr != 5'd0);
    assign w_wen1    = w_m_wen && (w_m_waddr != 5'd0) && !(w_wen2 && (w_s_waddr == w_m_waddr));
    assign w_commit  = (w_next == COMMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_drop      <= 1'b0;
            r_h_m_wen   <= 1'b0;
            r_h_m_waddr <= 5'd0;
            r_h_size    <= 2'd0;
            r_h_sign    <= 1'b0;
            r_h_lo      <= 2'd0;
            r_h_s_wen   <= 1'b0;
            r_h_s_waddr <= 5'd0;
            r_h_s_wdata <= 32'd0;
            wen1_a      <= 1'b0;
            waddr1_a    <= 5'd0;
            wdata1_a    <= 32'd0;
            wen2_a      <= 1'b0;
            waddr2_a    <= 5'd0;
            wdata2_a    <= 32'd0;
        end else begin
            r_state <= w_next;
            r_drop  <= w_drop_next;
            if (w_accept && m_is_load) begin
                r_h_m_wen   <= m_wen;
                r_h_m_waddr <= m_waddr;
                r_h_size    <= m_load_size;
                r_h_sign    <= m_load_sign;
                r_h_lo      <= m_addr_lo;
                r_h_s_wen   <= s_wen;
                r_h_s_waddr <= s_waddr;
                r_h_s_wdata <= s_wdata;
            end
            wen1_a   <= w_commit & w_wen1;
            waddr1_a <= w_commit ? w_m_waddr : 5'd0;
            wdata1_a <= w_commit ? w_m_wdata : 32'd0;
            wen2_a   <= w_commit & w_wen2;
            waddr2_a <= w_commit ? w_s_waddr : 5'd0;
            wdata2_a <= w_commit ? w_s_wdata : 32'd0;
        end
    end

`ifdef WB_DEBUG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_m_pc <= 32'd0;
            r_h_s_pc <= 32'd0;
            dbg_pc1  <= 32'd0;
            dbg_pc2  <= 32'd0;
        end else begin
            if (w_accept && m_is_load) begin
                r_h_m_pc <= m_pc;
                r_h_s_pc <= s_pc;
            end
            dbg_pc1 <= w_commit ? (w_load_done ? r_h_m_pc : m_pc) : 32'd0;
            dbg_pc2 <= w_commit ? (w_load_done ? r_h_s_pc : s_pc) : 32'd0;
        end
    end
`endif
endmodule

// File: tb/tb_wb_commit.sv
// tb_wb_commit: directed bench for wb_commit with a transaction-level reference model and per-cycle output compare.
module tb_wb_commit;
    logic        clk = 1'b0;
    logic        rst, flush, mem_valid, mem_ready;
    logic        m_wen, m_is_load, m_load_sign, s_wen, dmem_rvalid;
    logic [4:0]  m_waddr, s_waddr;
    logic [31:0] m_wdata, s_wdata, dmem_rdata;
    logic [1:0]  m_load_size, m_addr_lo;
    logic        wen1_a, wen2_a;
    logic [4:0]  waddr1_a, waddr2_a;
    logic [31:0] wdata1_a, wdata2_a;
`ifdef WB_DEBUG_EN
    logic [31:0] m_pc = 32'd0, s_pc = 32'd0, dbg_pc1, dbg_pc2;
`endif
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    wb_commit dut (
        .clk(clk), .rst(rst), .flush(flush), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .m_wen(m_wen), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_is_load(m_is_load),
        .m_load_size(m_load_size), .m_load_sign(m_load_sign), .m_addr_lo(m_addr_lo),
        .s_wen(s_wen), .s_waddr(s_waddr), .s_wdata(s_wdata),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
`ifdef WB_DEBUG_EN
        .m_pc(m_pc), .s_pc(s_pc), .dbg_pc1(dbg_pc1), .dbg_pc2(dbg_pc2),
`endif
        .wen1_a(wen1_a), .waddr1_a(waddr1_a), .wdata1_a(wdata1_a),
        .wen2_a(wen2_a), .waddr2_a(waddr2_a), .wdata2_a(wdata2_a)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit mw; bit [4:0] ma; bit [1:0] sz; bit sg; bit [1:0] lo;
        bit sw; bit [4:0] sa; bit [31:0] sd;
    } bundle_t;

    bundle_t     held;
    bit          armed = 0, waiting = 0;
    int          discard = 0;
    bit          e_wen1, e_wen2;
    bit [4:0]    e_a1, e_a2;
    bit [31:0]   e_d1, e_d2;

    function automatic bit [31:0] load_val(input bundle_t b, input bit [31:0] raw);
        bit [31:0] v;
        if (b.sz == 2'd0) begin
            v = (raw >> (8 * b.lo)) & 32'hFF;
            if (b.sg && v >= 128) v = v - 256;
        end else if (b.sz == 2'd1) begin
            v = (raw >> ((b.lo >= 2) ? 16 : 0)) & 32'hFFFF;
            if (b.sg && v >= 32768) v = v - 65536;
        end else begin
            v = raw;
        end
        return v;
    endfunction

    task automatic expect_write(input bundle_t b, input bit [31:0] md);
        e_wen2 = b.sw && b.sa != 0;
        e_wen1 = b.mw && b.ma != 0 && !(e_wen2 && b.sa == b.ma);
        e_a1 = b.ma; e_d1 = md;
        e_a2 = b.sa; e_d2 = b.sd;
    endtask

    function automatic bundle_t cur_bundle();
        bundle_t b;
        b.mw = m_wen; b.ma = m_waddr; b.sz = m_load_size; b.sg = m_load_sign; b.lo = m_addr_lo;
        b.sw = s_wen; b.sa = s_waddr; b.sd = s_wdata;
        return b;
    endfunction

    // reference model: a held bundle plus a count of load responses still owed to killed loads
    always @(posedge clk) begin
        e_wen1 = 0; e_wen2 = 0;
        if (rst) begin
            waiting = 0; discard = 0; armed = 1;
        end else if (waiting) begin
            if (flush) begin
                discard = discard + 1 - (dmem_rvalid ? 1 : 0);
                waiting = 0;
            end else if (dmem_rvalid) begin
                if (discard > 0) discard--;
                else begin
                    waiting = 0;
                    expect_write(held, load_val(held, dmem_rdata));
                end
            end
        end else begin
            if (dmem_rvalid && discard > 0) discard--;
            if (mem_valid && !flush) begin
                if (m_is_load) begin
                    held = cur_bundle();
                    waiting = 1;
                end else begin
                    expect_write(cur_bundle(), m_wdata);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("mem_ready", {31'd0, mem_ready}, {31'd0, !waiting && !flush});
            chk("wen1", {31'd0, wen1_a}, {31'd0, e_wen1});
            chk("wen2", {31'd0, wen2_a}, {31'd0, e_wen2});
            if (e_wen1) begin
                chk("waddr1", {27'd0, waddr1_a}, {27'd0, e_a1});
                chk("wdata1", wdata1_a, e_d1);
            end
            if (e_wen2) begin
                chk("waddr2", {27'd0, waddr2_a}, {27'd0, e_a2});
                chk("wdata2", wdata2_a, e_d2);
            end
        end
    end

    task automatic clear();
        rst = 0; flush = 0; mem_valid = 0; dmem_rvalid = 0; dmem_rdata = 0;
        m_wen = 0; m_waddr = 0; m_wdata = 0; m_is_load = 0; m_load_size = 0; m_load_sign = 0; m_addr_lo = 0;
        s_wen = 0; s_waddr = 0; s_wdata = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear();
    endtask

    task automatic alu(input bit mw, input bit [4:0] ma, input bit [31:0] md, input bit sw, input bit [4:0] sa, input bit [31:0] sd);
        mem_valid = 1; m_is_load = 0;
        m_wen = mw; m_waddr = ma; m_wdata = md; s_wen = sw; s_waddr = sa; s_wdata = sd;
    endtask

    task automatic ld(input bit [4:0] ma, input bit [1:0] sz, input bit sg, input bit [1:0] lo, input bit sw, input bit [4:0] sa, input bit [31:0] sd);
        mem_valid = 1; m_is_load = 1; m_wen = 1; m_waddr = ma; m_wdata = 32'hDEAD_BEEF;
        m_load_size = sz; m_load_sign = sg; m_addr_lo = lo; s_wen = sw; s_waddr = sa; s_wdata = sd;
    endtask

    task automatic rv(input bit [31:0] d);
        dmem_rvalid = 1; dmem_rdata = d;
    endtask

    initial begin
        clear();
        rst = 1;
        tick();
        rst = 1;
        tick();
        chk("rst_wen1", {31'd0, wen1_a}, 32'd0);
        chk("rst_wdata1", wdata1_a, 32'd0);
        chk("rst_waddr2", {27'd0, waddr2_a}, 32'd0);
        chk("rst_ready", {31'd0, mem_ready}, 32'd1);
        // back-to-back non-load bundles
        alu(1, 3, 1, 1, 4, 2); tick();
        chk("t1_wdata1", wdata1_a, 32'd1);
        chk("t1_waddr2", {27'd0, waddr2_a}, 32'd4);
        alu(1, 8, 32'h10, 1, 9, 32'h20); tick();
        alu(1, 10, 32'h30, 0, 11, 32'h40); tick();
        chk("t1_third_wen2", {31'd0, wen2_a}, 32'd0);
        tick();
        chk("t1_idle_wen1", {31'd0, wen1_a}, 32'd0);
        // signed byte, 3-cycle load latency
        ld(6, 2'd0, 1, 2'd2, 0, 0, 0); tick();
        chk("t2_ready_wait", {31'd0, mem_ready}, 32'd0);
        tick(); tick();
        rv(32'h0080_0000); tick();
        chk("t2_sbyte", wdata1_a, 32'hFFFF_FF80);
        chk("t2_sbyte_wen", {31'd0, wen1_a}, 32'd1);
        ld(7, 2'd1, 0, 2'd2, 1, 12, 32'h77); tick();
        rv(32'h0080_0000); tick();
        chk("t2_uhalf", wdata1_a, 32'h0000_0080);
        chk("t2_slave", wdata2_a, 32'h77);
        ld(13, 2'd1, 1, 2'd0, 0, 0, 0); tick();
        rv(32'h1234_8001); tick();
        chk("t2_shalf_lo", wdata1_a, 32'hFFFF_8001);
        ld(14, 2'd3, 0, 2'd1, 0, 0, 0); tick();
        rv(32'hCAFE_F00D); tick();
        chk("t2_size3_word", wdata1_a, 32'hCAFE_F00D);
        // same destination on both lanes, slave wins
        alu(1, 5, 32'h11, 1, 5, 32'h22); tick();
        chk("t3_wen1", {31'd0, wen1_a}, 32'd0);
        chk("t3_wen2", {31'd0, wen2_a}, 32'd1);
        chk("t3_wdata2", wdata2_a, 32'h22);
        // r0 destination suppressed
        alu(1, 0, 32'h55, 1, 7, 9); tick();
        chk("t4_wen1", {31'd0, wen1_a}, 32'd0);
        chk("t4_wen2", {31'd0, wen2_a}, 32'd1);
        // flush in WAIT, stale response dropped
        ld(15, 2'd2, 0, 2'd0, 0, 0, 0); tick();
        flush = 1; tick();
        ld(16, 2'd2, 0, 2'd0, 1, 17, 32'h5); tick();
        rv(32'hAAAA_AAAA); tick();
        chk("t5_drop_wen1", {31'd0, wen1_a}, 32'd0);
        rv(32'h1234_5678); tick();
        chk("t5_wdata1", wdata1_a, 32'h1234_5678);
        chk("t5_waddr1", {27'd0, waddr1_a}, 32'd16);
        tick();
        // flush in COMMIT blocks the next bundle
        alu(1, 18, 32'h1, 0, 0, 0); tick();
        alu(1, 19, 32'h2, 0, 0, 0); flush = 1; tick();
        chk("flush_commit_wen1", {31'd0, wen1_a}, 32'd0);
        // stray rvalid while idle
        rv(32'hFFFF_FFFF); tick();
        chk("stray_rvalid", {31'd0, wen1_a}, 32'd0);
        // reset mid-WAIT
        ld(20, 2'd2, 0, 2'd0, 1, 21, 32'h3); tick();
        rst = 1; tick();
        chk("t6_ready", {31'd0, mem_ready}, 32'd1);
        chk("t6_wen2", {31'd0, wen2_a}, 32'd0);
        chk("t6_wdata2", wdata2_a, 32'd0);
        rv(32'h9999_9999); tick();
        chk("t6_no_write", {31'd0, wen1_a}, 32'd0);
        alu(1, 22, 32'h66, 0, 0, 0); tick();
        chk("t6_after", wdata1_a, 32'h66);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
